// File: rtl/core_mem_copier.sv
// Word-granular memory copy/fill engine driving a single-port synchronous memory.
// Optional MEM_COPIER_CHECKSUM_EN adds a running sum of every written word.
module core_mem_copier #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic [DATA_W-1:0]   cmd_pattern,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   checksum,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_WR,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_op;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W:0]     r_rem;
    logic [DATA_W-1:0]   r_pattern;
    logic [DATA_W-1:0]   r_data_q;
    logic                w_accept;
    logic                w_last;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_last   = (r_rem == (ADDR_W+1)'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_len == '0)
                        w_next = S_DONE;
                    else if (cmd_op)
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD:    w_next = S_LAT;
            S_LAT:   w_next = S_WR;
            S_WR: begin
                if (w_last)
                    w_next = S_DONE;
                else if (r_op)
                    w_next = S_WR;
                else
                    w_next = S_RD;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_rem     <= '0;
            r_pattern <= '0;
            r_data_q  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op      <= cmd_op;
                r_src     <= cmd_src;
                r_dst     <= cmd_dst;
                r_rem     <= cmd_len;
                r_pattern <= cmd_pattern;
            end
            // Read data arrives one cycle after the RD strobe, i.e. during LAT.
            if (r_state == S_LAT)
                r_data_q <= readdata;
            if (r_state == S_WR) begin
                r_dst <= r_dst + 1'b1;
                if (!r_op)
                    r_src <= r_src + 1'b1;
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign chipselect = (r_state == S_RD) || (r_state == S_WR);
    assign write      = (r_state == S_WR);
    assign address    = (r_state == S_RD) ? r_src : r_dst;
    assign writedata  = r_op ? r_pattern : r_data_q;
    assign byteenable = '1;
    assign clken      = 1'b1;

`ifdef MEM_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Cleared on acceptance, so the sum holds through DONE/IDLE until the next command.
    always_ff @(posedge clk) begin
        if (reset)
            r_checksum <= '0;
        else if (w_accept)
            r_checksum <= '0;
        else if (r_state == S_WR)
            r_checksum <= r_checksum + writedata;
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_core_mem_copier.sv
// Directed bench for core_mem_copier with a behavioural one-cycle-latency memory.
// Checksum expectations follow MEM_COPIER_CHECKSUM_EN.
module tb_core_mem_copier;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
`ifdef MEM_COPIER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_op;
    logic [ADDR_W-1:0]   cmd_src;
    logic [ADDR_W-1:0]   cmd_dst;
    logic [ADDR_W:0]     cmd_len;
    logic [DATA_W-1:0]   cmd_pattern;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   checksum;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                clken;
    logic [DATA_W-1:0]   readdata;

    core_mem_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_len    (cmd_len),
        .cmd_pattern(cmd_pattern),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .clken      (clken),
        .readdata   (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model plus write/strobe logger
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] wa [0:63];
    logic [DATA_W-1:0] wd [0:63];
    int                wn;
    int                cs_cnt;
    int                done_cnt;

    initial begin
        wn       = 0;
        cs_cnt   = 0;
        done_cnt = 0;
        readdata = '0;
    end

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        if (chipselect && !write)
            readdata <= mem[address];
        if (chipselect && write) begin
            mem[address] <= writedata;
            if (wn < 64) begin
                wa[wn] <= address;
                wd[wn] <= writedata;
            end
            wn <= wn + 1;
        end
        if (chipselect)
            cs_cnt <= cs_cnt + 1;
        if (done)
            done_cnt <= done_cnt + 1;
    end

    int   n_assert;
    int   n_fail;
    logic cs_hist   [0:63];
    logic busy_hist [0:63];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input logic [ADDR_W:0] len, input logic [DATA_W-1:0] pat);
        @(negedge clk);
        cmd_op      = op;
        cmd_src     = src;
        cmd_dst     = dst;
        cmd_len     = len;
        cmd_pattern = pat;
        cmd_valid   = 1'b1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the acceptance edge; cyc stays -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            cs_hist[k]   = chipselect;
            busy_hist[k] = busy;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_ck(input logic [DATA_W-1:0] v);
        return CK_EN ? v : '0;
    endfunction

    int cyc;
    int wn0;
    int cs0;
    int dn0;

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 1'b0;
        cmd_src     = '0;
        cmd_dst     = '0;
        cmd_len     = '0;
        cmd_pattern = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_cs", 64'(chipselect), 64'(0));
        check("rst_write", 64'(write), 64'(0));
        check("rst_address", 64'(address), 64'(0));
        check("rst_writedata", 64'(writedata), 64'(0));
        check("rst_checksum", 64'(checksum), 64'(0));
        check("byteenable", 64'(byteenable), 64'(4'hF));
        check("clken", 64'(clken), 64'(1));

        // Fill 4 words at 0x0010
        wn0 = wn; cs0 = cs_cnt;
        issue(1'b1, 13'h0, 13'h0010, 14'd4, 32'hDEADBEEF);
        wait_done(cyc);
        check("fill_done_cycle", 64'(cyc), 64'(5));
        check("fill_busy_at_done", 64'(busy), 64'(0));
        for (int i = 1; i <= 4; i++) begin
            check("fill_busy", 64'(busy_hist[i]), 64'(1));
            check("fill_cs", 64'(cs_hist[i]), 64'(1));
        end
        check("fill_nwrites", 64'(wn - wn0), 64'(4));
        check("fill_cs_cnt", 64'(cs_cnt - cs0), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", 64'(wa[wn0+i]), 64'(13'h0010 + 13'(i)));
            check("fill_data", 64'(wd[wn0+i]), 64'(32'hDEADBEEF));
        end
        check("fill_checksum", 64'(checksum), 64'(exp_ck(32'h7AB6FBBC)));
        @(negedge clk);
        check("fill_done_pulse", 64'(done), 64'(0));
        check("fill_idle_ready", 64'(cmd_ready), 64'(1));
        check("fill_checksum_hold", 64'(checksum), 64'(exp_ck(32'h7AB6FBBC)));

        // Copy 2 words 0x0000 -> 0x0100
        load(13'h0000, 32'h11111111);
        load(13'h0001, 32'h22222222);
        wn0 = wn; cs0 = cs_cnt;
        issue(1'b0, 13'h0000, 13'h0100, 14'd2, 32'hFFFFFFFF);
        wait_done(cyc);
        check("copy_done_cycle", 64'(cyc), 64'(7));
        check("copy_cs_rd1", 64'(cs_hist[1]), 64'(1));
        check("copy_cs_lat1", 64'(cs_hist[2]), 64'(0));
        check("copy_cs_lat2", 64'(cs_hist[5]), 64'(0));
        check("copy_cs_cnt", 64'(cs_cnt - cs0), 64'(4));
        check("copy_nwrites", 64'(wn - wn0), 64'(2));
        check("copy_addr0", 64'(wa[wn0]), 64'(13'h0100));
        check("copy_data0", 64'(wd[wn0]), 64'(32'h11111111));
        check("copy_addr1", 64'(wa[wn0+1]), 64'(13'h0101));
        check("copy_data1", 64'(wd[wn0+1]), 64'(32'h22222222));
        check("copy_checksum", 64'(checksum), 64'(exp_ck(32'h33333333)));

        // Zero-length command
        cs0 = cs_cnt;
        issue(1'b1, 13'h0, 13'h0200, 14'd0, 32'h12345678);
        wait_done(cyc);
        check("len0_done_cycle", 64'(cyc), 64'(1));
        check("len0_cs_cnt", 64'(cs_cnt - cs0), 64'(0));
        check("len0_checksum", 64'(checksum), 64'(0));

        // Fill across the top of the address space
        wn0 = wn;
        issue(1'b1, 13'h0, 13'h1FFE, 14'd4, 32'hA5A5A5A5);
        wait_done(cyc);
        check("wrap_done_cycle", 64'(cyc), 64'(5));
        check("wrap_nwrites", 64'(wn - wn0), 64'(4));
        for (int i = 0; i < 4; i++)
            check("wrap_addr", 64'(wa[wn0+i]), 64'(13'(13'h1FFE + 13'(i))));
        check("wrap_checksum", 64'(checksum), 64'(exp_ck(32'h96969694)));

        // Ignored command while busy, then reset during copy word 2
        load(13'h0020, 32'hAAAA0001);
        load(13'h0021, 32'hAAAA0002);
        load(13'h0022, 32'hAAAA0003);
        wn0 = wn; cs0 = cs_cnt; dn0 = done_cnt;
        issue(1'b0, 13'h0020, 13'h0040, 14'd3, 32'h0);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_dst   = 13'h0300;
        cmd_len   = 14'd5;
        @(negedge clk);
        check("busy_ready", 64'(cmd_ready), 64'(0));
        check("busy_busy", 64'(busy), 64'(1));
        check("busy_rd_addr", 64'(address), 64'(13'h0020));
        check("busy_rd_write", 64'(write), 64'(0));
        @(negedge clk);
        check("busy_lat_cs", 64'(chipselect), 64'(0));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_wr_write", 64'(write), 64'(1));
        check("busy_wr_addr", 64'(address), 64'(13'h0040));
        check("busy_wr_data", 64'(writedata), 64'(32'hAAAA0001));
        @(negedge clk);
        check("w2_rd_addr", 64'(address), 64'(13'h0021));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs", 64'(chipselect), 64'(0));
        check("abort_ready", 64'(cmd_ready), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_address", 64'(address), 64'(0));
        check("abort_checksum", 64'(checksum), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - dn0), 64'(0));
        check("abort_cs_cnt", 64'(cs_cnt - cs0), 64'(3));
        check("abort_nwrites", 64'(wn - wn0), 64'(1));
        check("abort_write_addr", 64'(wa[wn0]), 64'(13'h0040));

        // Engine usable again after the abort
        wn0 = wn;
        issue(1'b1, 13'h0, 13'h0005, 14'd1, 32'h0000CAFE);
        wait_done(cyc);
        check("post_done_cycle", 64'(cyc), 64'(2));
        check("post_addr", 64'(wa[wn0]), 64'(13'h0005));
        check("post_checksum", 64'(checksum), 64'(exp_ck(32'h0000CAFE)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem_copier.md
CORE_MEM_COPIER -- requirements
Module: core_mem_copier

Interface
REQ-001 Parameter ADDR_W, default 13, width of word address on the memory-side master port.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-007 cmd_op  input  1  0 = copy, 1 = fill.
REQ-008 cmd_src  input  ADDR_W  copy source word address; ignored for fill.
REQ-009 cmd_dst  input  ADDR_W  destination word address.
REQ-010 cmd_len  input  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-011 cmd_pattern  input  DATA_W  fill value; ignored for copy.
REQ-012 busy  output  1  high from acceptance until the done pulse.
REQ-013 done  output  1  one-cycle pulse at completion.
REQ-014 checksum  output  DATA_W  sum of written words for the last command.
REQ-015 address  output  ADDR_W  memory word address.
REQ-016 byteenable  output  DATA_W/8  always all ones.
REQ-017 chipselect  output  1  memory access strobe.
REQ-018 write  output  1  write qualifier, valid only with chipselect.
REQ-019 writedata  output  DATA_W  write data.
REQ-020 clken  output  1  memory clock enable, constant 1.
REQ-021 readdata  input  DATA_W  memory read data, valid exactly one cycle after a read cycle (chipselect=1, write=0).

Function
REQ-022 States: IDLE, RD, LAT, WR, DONE; cmd_ready = (state==IDLE).
REQ-023 Acceptance latches op, src, dst, len, pattern, and clears checksum; next state: DONE if len==0, else RD for copy, WR for fill.
REQ-024 RD: chipselect=1, write=0, address=src pointer; next state LAT.
REQ-025 LAT: chipselect=0; readdata registered into data_q at the end of the cycle; next state WR.
REQ-026 WR: chipselect=1, write=1, address=dst pointer, writedata=data_q (copy) or pattern (fill).
REQ-027 WR update: dst increments, src increments (copy), remaining decrements.
REQ-028 WR exit: if remaining was 1, next state DONE; else RD (copy) or WR (fill).
REQ-029 Throughput: copy takes 3 cycles per word; fill takes 1 cycle per word.
REQ-030 DONE: done=1 for one cycle, busy=0 in the same cycle; next state IDLE.
REQ-031 Pointers wrap modulo 2^ADDR_W; len=2^ADDR_W covers the whole memory exactly once.
REQ-032 cmd_valid while not IDLE is ignored; the command is not queued.
REQ-033 Overlapping regions are copied strictly in ascending address order; no overlap correction.
REQ-034 In IDLE, LAT and DONE: chipselect=0 and write=0.

Reset
REQ-035 On reset, state=IDLE, and chipselect, write, done, busy = 0.
REQ-036 On reset, address, writedata, checksum and all internal pointers/counters = 0.
REQ-037 Reset mid-operation abandons the command in the same edge; no further memory access and no done pulse.

Configuration
REQ-038 With MEM_COPIER_CHECKSUM_EN defined, checksum accumulates writedata modulo 2^DATA_W on every WR cycle and holds its value after done until the next acceptance.
REQ-039 Without MEM_COPIER_CHECKSUM_EN, checksum is tied to 0 and no accumulator is synthesized.

Verification
REQ-040 Fill dst=0x0010, len=4, pattern=0xDEADBEEF -> four consecutive WR cycles at 0x0010..0x0013; done 5 cycles after acceptance; checksum=0x7AB6FBBC (with macro).
REQ-041 Copy src=0x0000, dst=0x0100, len=2, memory holds 0x11111111, 0x22222222 -> writes 0x11111111 to 0x0100 and 0x22222222 to 0x0101; 6 memory-phase cycles; checksum=0x33333333.
REQ-042 cmd_len=0 -> no chipselect; done one cycle after acceptance; checksum=0.
REQ-043 Fill dst=0x1FFE, len=4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-044 Second cmd_valid while busy -> not accepted, no effect; reset asserted during copy word 2 -> chipselect=0 on the next cycle, no done pulse, cmd_ready=1.
